// File: rtl/tdc_readout_sched.sv
// Readout scheduler for TDC pin-capture channels: timestamps strobes with a shared
// coarse counter, buffers them per channel and round-robins them onto one event stream.
module tdc_readout_sched #(
  parameter int N_CH     = 4,
  parameter int COARSE_W = 16,
  parameter int DEPTH    = 2
) (
  input  logic                    clk300,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [N_CH-1:0]         ch_str,
  input  logic [3*N_CH-1:0]       ch_ptime,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(N_CH)-1:0] out_ch,
  output logic [COARSE_W-1:0]     out_coarse,
  output logic [2:0]              out_fine,
  output logic [N_CH-1:0]         ovf,
  input  logic                    clr_ovf,
  output logic                    busy
);

  localparam int CH_W = $clog2(N_CH);
  localparam int AW   = $clog2(DEPTH);
  localparam int PW   = AW + 1;
  localparam int EW   = COARSE_W + 3;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;

  logic [COARSE_W-1:0]        r_coarse;
  logic                       r_en_d;
  logic [COARSE_W-1:0]        w_ts;

  logic [N_CH-1:0]            w_nempty;
  logic [N_CH-1:0]            w_push;
  logic [N_CH-1:0]            w_pop;
  logic [N_CH-1:0]            w_drop;
  logic [N_CH-1:0][EW-1:0]    w_head;

  logic [CH_W-1:0]            r_rr_ptr;
  logic [CH_W-1:0]            w_gnt_ch;
  logic                       w_gnt_any;
  logic                       w_load;
  logic                       w_busy;

  logic                       r_out_valid;
  logic [CH_W-1:0]            r_out_ch;
  logic [COARSE_W-1:0]        r_out_coarse;
  logic [2:0]                 r_out_fine;
  logic [N_CH-1:0]            r_ovf;

  // A run starts with timestamp 0; the counter then carries on from there.
  assign w_ts = (enable && !r_en_d) ? '0 : r_coarse;

  always_ff @(posedge clk300 or posedge rst) begin
    if (rst) begin
      r_coarse <= '0;
      r_en_d   <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      r_en_d <= enable;
      if (enable) r_coarse <= w_ts + 1'b1;
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic [EW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic          w_full;

    assign w_nempty[gi] = (r_wptr != r_rptr);
    assign w_full       = ((r_wptr - r_rptr) == PW'(DEPTH));
    assign w_pop[gi]    = w_load & w_gnt_any & (w_gnt_ch == CH_W'(gi));
    // A full FIFO that is being popped this edge still has room for the new entry.
    assign w_push[gi]   = enable & ch_str[gi] & (~w_full | w_pop[gi]);
    assign w_drop[gi]   = enable & ch_str[gi] & w_full & ~w_pop[gi];
    assign w_head[gi]   = r_mem[r_rptr[AW-1:0]];

    // NOTE: the storage array has no reset; occupancy is defined by the pointers alone.
    always_ff @(posedge clk300) begin
      if (w_push[gi]) r_mem[r_wptr[AW-1:0]] <= {w_ts, ch_ptime[3*gi +: 3]};
    end

    always_ff @(posedge clk300 or posedge rst) begin
      if (rst) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push[gi]) r_wptr <= r_wptr + 1'b1;
        if (w_pop[gi])  r_rptr <= r_rptr + 1'b1;
      end
    end
  end

  // First non-empty channel at or after the pointer: scan backwards so the
  // closest candidate is the last one written.
  always_comb begin
    int              idx;
    logic [CH_W-1:0] cand;
    // NOTE: every combinational output gets a default first so no latch is inferred.
    w_gnt_any = 1'b0;
    w_gnt_ch  = '0;
    idx       = 0;
    cand      = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      idx  = (int'(r_rr_ptr) + k) % N_CH;
      cand = CH_W'(idx);
      if (w_nempty[cand]) begin
        w_gnt_any = 1'b1;
        w_gnt_ch  = cand;
      end
    end
  end

  assign w_load = !r_out_valid || out_ready;
  assign w_busy = (|w_nempty) || r_out_valid;

  always_ff @(posedge clk300 or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_ch     <= '0;
      r_out_coarse <= '0;
      r_out_fine   <= '0;
      r_rr_ptr     <= '0;
    end else if (w_load) begin
      r_out_valid <= w_gnt_any;
      if (w_gnt_any) begin
        r_out_ch                   <= w_gnt_ch;
        {r_out_coarse, r_out_fine} <= w_head[w_gnt_ch];
        r_rr_ptr <= (w_gnt_ch == CH_W'(N_CH - 1)) ? '0 : w_gnt_ch + 1'b1;
      end
    end
  end

  // Set wins over clear so a drop coinciding with clr_ovf is not lost.
  always_ff @(posedge clk300 or posedge rst) begin
    if (rst) r_ovf <= '0;
    else     r_ovf <= (r_ovf & ~{N_CH{clr_ovf}}) | w_drop;
  end

  always_ff @(posedge clk300 or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (enable) w_state_nxt = S_RUN;
      S_RUN:   if (!enable) w_state_nxt = w_busy ? S_DRAIN : S_IDLE;
      S_DRAIN: begin
        if (enable)       w_state_nxt = S_RUN;
        else if (!w_busy) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign out_valid  = r_out_valid;
  assign out_ch     = r_out_ch;
  assign out_coarse = r_out_coarse;
  assign out_fine   = r_out_fine;
  assign ovf        = r_ovf;
  assign busy       = w_busy;

endmodule

// File: tb/tb_tdc_readout_sched.sv
// Scoreboard bench for tdc_readout_sched: the driver queues expected events, a
// negedge monitor pops and compares on every accepted transfer.
module tb_tdc_readout_sched;

  logic        clk300 = 1'b0;
  logic        rst;
  logic        enable;
  logic [3:0]  ch_str;
  logic [11:0] ch_ptime;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_ch;
  logic [15:0] out_coarse;
  logic [2:0]  out_fine;
  logic [3:0]  ovf;
  logic        clr_ovf;
  logic        busy;

  tdc_readout_sched #(.N_CH(4), .COARSE_W(16), .DEPTH(2)) dut (
    .clk300    (clk300),
    .rst       (rst),
    .enable    (enable),
    .ch_str    (ch_str),
    .ch_ptime  (ch_ptime),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .out_coarse(out_coarse),
    .out_fine  (out_fine),
    .ovf       (ovf),
    .clr_ovf   (clr_ovf),
    .busy      (busy)
  );

  always #5 clk300 = ~clk300;

  typedef struct packed {
    logic [1:0]  ch;
    logic [15:0] coarse;
    logic [2:0]  fine;
  } ev_t;

  ev_t         sb[$];
  ev_t         mon_e;
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [15:0] m_cnt;
  logic        m_en_d;
  logic [15:0] t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Timestamp the coarse counter will attach at the coming edge.
  function automatic logic [15:0] ts_now();
    return (enable && !m_en_d) ? 16'd0 : m_cnt;
  endfunction

  task automatic tick();
    if (enable) m_cnt = ts_now() + 16'd1;
    m_en_d = enable;
    @(posedge clk300);
    #1;
  endtask

  task automatic push(input logic [1:0] ch, input logic [15:0] coarse, input logic [2:0] fine);
    ev_t e;
    e.ch     = ch;
    e.coarse = coarse;
    e.fine   = fine;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk300);
    #1;
    @(posedge clk300);
    #1;
    rst    = 1'b0;
    m_cnt  = 16'd0;
    m_en_d = 1'b0;
    sb.delete();
  endtask

  task automatic wait_drain(input int limit, input string name);
    int n = 0;
    while (sb.size() != 0 && n < limit) begin
      tick();
      n++;
    end
    check(name, sb.size(), 0);
    repeat (3) tick();
  endtask

  always @(negedge clk300) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_event: got ch=%0d coarse=0x%0h fine=%0d, expected no event at %0t",
                 out_ch, out_coarse, out_fine, $time);
      end else begin
        mon_e = sb.pop_front();
        check("ev_ch", out_ch, mon_e.ch);
        check("ev_coarse", out_coarse, mon_e.coarse);
        check("ev_fine", out_fine, mon_e.fine);
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got no end of test, expected completion by %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; ch_str = '0; ch_ptime = '0;
    out_ready = 1'b0; clr_ovf = 1'b0; m_cnt = 16'd0; m_en_d = 1'b0;
    repeat (2) @(posedge clk300);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_ch", out_ch, 0);
    check("rst_coarse", out_coarse, 0);
    check("rst_fine", out_fine, 0);
    check("rst_ovf", ovf, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;

    // Single strobe on ch2 at coarse 10, held while the consumer stalls.
    enable = 1'b1;
    repeat (10) tick();
    ch_str = 4'b0100; ch_ptime = {3'd0, 3'd5, 3'd0, 3'd0};
    push(2'd2, 16'd10, 3'd5);
    tick();
    ch_str = '0;
    check("t1_latency_valid", out_valid, 0);
    check("t1_busy_fifo", busy, 1);
    tick();
    check("t1_valid", out_valid, 1);
    check("t1_ch", out_ch, 2);
    check("t1_coarse", out_coarse, 16'd10);
    check("t1_fine", out_fine, 5);
    check("t1_busy", busy, 1);
    repeat (3) tick();
    check("t1_hold_valid", out_valid, 1);
    check("t1_hold_coarse", out_coarse, 16'd10);
    out_ready = 1'b1;
    tick();
    check("t1_after_valid", out_valid, 0);
    check("t1_after_busy", busy, 0);

    // All four channels at once from pointer 0.
    do_reset();
    ch_str = 4'b1111; ch_ptime = {3'd4, 3'd3, 3'd2, 3'd1};
    t = ts_now();
    for (int k = 0; k < 4; k++) push(2'(k), t, 3'(k + 1));
    tick();
    ch_str = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t2_valid", out_valid, 1);
      check("t2_ch", out_ch, k);
    end
    tick();
    check("t2_idle", out_valid, 0);
    // Pointer back at 0: ch0 must win over ch3.
    ch_str = 4'b1001; ch_ptime = {3'd7, 3'd0, 3'd0, 3'd6};
    t = ts_now();
    push(2'd0, t, 3'd6);
    push(2'd3, t, 3'd7);
    tick();
    ch_str = '0;
    tick();
    check("t2_rr_first", out_ch, 0);
    tick();
    check("t2_rr_second", out_ch, 3);
    tick();
    check("t2_rr_idle", out_valid, 0);
    check("t2_drain", sb.size(), 0);

    // Backpressure on ch1: three held, fourth dropped.
    out_ready = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      ch_str = 4'b0010; ch_ptime = {3'd0, 3'd0, 3'(j), 3'd0};
      if (j == 1) t = ts_now();
      if (j < 4) push(2'd1, ts_now(), 3'(j));
      tick();
    end
    ch_str = '0;
    check("t3_valid", out_valid, 1);
    check("t3_ch", out_ch, 1);
    check("t3_fine", out_fine, 1);
    check("t3_coarse", out_coarse, t);
    check("t3_ovf", ovf, 4'b0010);
    repeat (2) tick();
    check("t3_hold_fine", out_fine, 1);
    check("t3_hold_coarse", out_coarse, t);
    out_ready = 1'b1;
    wait_drain(20, "t3_drain");
    check("t3_ovf_sticky", ovf, 4'b0010);

    // Full FIFO popped and pushed on the same edge.
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("t4_clr", ovf, 0);
    out_ready = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      ch_str = 4'b0001; ch_ptime = {9'd0, 3'(j)};
      push(2'd0, ts_now(), 3'(j));
      tick();
    end
    out_ready = 1'b1;
    ch_str = 4'b0001; ch_ptime = {9'd0, 3'd4};
    push(2'd0, ts_now(), 3'd4);
    tick();
    ch_str = '0;
    check("t4_nodrop", ovf, 0);
    wait_drain(20, "t4_drain");

    // Drop on ch2 coinciding with clr_ovf: set wins.
    out_ready = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      ch_str = 4'b0100; ch_ptime = {3'd0, 3'(j), 3'd0, 3'd0};
      clr_ovf = (j == 4);
      if (j < 4) push(2'd2, ts_now(), 3'(j));
      tick();
    end
    ch_str = '0; clr_ovf = 1'b0;
    check("t4_set_wins", ovf, 4'b0100);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("t4_clr_again", ovf, 0);
    out_ready = 1'b1;
    wait_drain(20, "t4b_drain");

    // Coarse wrap.
    begin
      int n = 0;
      while (ts_now() != 16'hFFFF && n < 70000) begin
        tick();
        n++;
      end
    end
    ch_str = 4'b1000; ch_ptime = {3'd6, 9'd0};
    push(2'd3, 16'hFFFF, 3'd6);
    tick();
    ch_ptime = {3'd7, 9'd0};
    push(2'd3, 16'h0000, 3'd7);
    tick();
    ch_str = '0;
    wait_drain(20, "t5_drain");

    // Drain after enable falls; strobes during drain are ignored.
    out_ready = 1'b0;
    ch_str = 4'b0111; ch_ptime = {3'd0, 3'd3, 3'd2, 3'd1};
    t = ts_now();
    push(2'd0, t, 3'd1);
    push(2'd1, t, 3'd2);
    push(2'd2, t, 3'd3);
    tick();
    ch_str = '0; enable = 1'b0;
    tick();
    ch_str = 4'b1111; ch_ptime = 12'hFFF;
    repeat (2) tick();
    ch_str = '0;
    check("t6_busy", busy, 1);
    check("t6_ovf", ovf, 0);
    check("t6_head", out_ch, 0);
    out_ready = 1'b1;
    wait_drain(20, "t6_drain");
    check("t6_idle_busy", busy, 0);
    check("t6_idle_valid", out_valid, 0);

    // Re-enable restarts the counter at 0.
    enable = 1'b1;
    ch_str = 4'b0010; ch_ptime = {3'd0, 3'd0, 3'd2, 3'd0};
    push(2'd1, 16'd0, 3'd2);
    tick();
    ch_str = '0;
    wait_drain(20, "t6_restart");

    // Asynchronous reset mid-drain.
    out_ready = 1'b0;
    ch_str = 4'b1111; ch_ptime = 12'o5555;
    tick();
    ch_str = '0; enable = 1'b0;
    tick();
    check("t7_pre_valid", out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("t7_valid", out_valid, 0);
    check("t7_ch", out_ch, 0);
    check("t7_coarse", out_coarse, 0);
    check("t7_fine", out_fine, 0);
    check("t7_ovf", ovf, 0);
    check("t7_busy", busy, 0);
    sb.delete();
    @(posedge clk300);
    #1;
    rst = 1'b0; m_cnt = 16'd0; m_en_d = 1'b0;
    repeat (3) tick();
    check("t7_post_valid", out_valid, 0);
    check("t7_post_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tdc_readout_sched.md
Name: tdc_readout_sched

Overview:
- Readout scheduler for N_CH pin-capture channels, each producing a one-cycle strobe (str) and a 3-bit fine arrival time (ptime) in the clk300 domain.
- Timestamps each strobe with a shared coarse counter and buffers it in a per-channel FIFO.
- Round-robin arbitrates all channels onto one valid/ready event stream.
- Sits between the capture channels and the downstream event writer/logger.

Parameters:
N_CH, 4, number of capture channels (2..16)
COARSE_W, 16, width of coarse clk300 cycle counter
DEPTH, 2, entries per channel FIFO (power of two, >=2)

Ports:
clk300  input  1  system clock (300 MHz capture clock)
rst  input  1  asynchronous active-high reset
enable  input  1  capture enable; coarse counter runs and strobes are accepted only while high
ch_str  input  N_CH  per-channel one-cycle event strobe
ch_ptime  input  3*N_CH  fine time per channel; channel i at bits [3i+2:3i], valid when ch_str[i]=1
out_valid  output  1  event word valid
out_ready  input  1  downstream accepts event when high together with out_valid
out_ch  output  $clog2(N_CH)  source channel of event
out_coarse  output  COARSE_W  coarse timestamp of event
out_fine  output  3  fine time (ptime) of event
ovf  output  N_CH  sticky per-channel drop flag
clr_ovf  input  1  clears all ovf bits
busy  output  1  high while any FIFO is non-empty or out_valid=1

Behaviour:
- Reset (async, any time, including mid-transfer):
  - out_valid=0; out_ch, out_coarse and out_fine = 0; ovf=0; busy=0.
  - All FIFOs empty; coarse counter=0; round-robin pointer=0; FSM=IDLE.
- Coarse counter:
  - Increments by 1 each clk300 edge while enable=1; wraps 2^COARSE_W-1 -> 0.
  - Holds its value while enable=0.
  - Cleared to 0 on the first edge where enable is sampled high after being low (start of a run).
  - The timestamp attached to a strobe is the counter value before that edge's increment.
- Capture:
  - At each edge where enable=1 and ch_str[i]=1, push {coarse, ch_ptime[i]} into FIFO i.
  - If FIFO i is full and not popped at that edge, drop the event and set ovf[i].
  - If FIFO i is full and popped at the same edge, accept the push (no drop).
  - Strobes arriving while enable=0 are ignored and do not set ovf.
- Arbitration:
  - Candidates are the non-empty FIFOs.
  - Grant goes to the first non-empty channel at or after the RR pointer, modulo N_CH.
  - After a grant to channel g, pointer = (g+1) mod N_CH. With no grant, the pointer holds.
- Output register:
  - Loads the granted entry, and FIFO g pops, when out_valid=0 or (out_valid=1 and out_ready=1).
  - This gives zero-bubble back-to-back transfer.
  - With out_valid=1 and out_ready=0, out_* are held stable and no pop occurs.
  - out_valid drops to 0 after an accepted transfer only if no candidate exists.
- Latency: a strobe sampled at edge k, into an empty system, gives out_valid=1 with that event after edge k+1.
- FSM:
  - IDLE: enable=0 and nothing buffered.
  - RUN: enable=1.
  - DRAIN: enable=0 with FIFOs non-empty or out_valid=1.
  - Transitions: IDLE->RUN on enable=1. RUN->DRAIN on enable=0 if busy, otherwise RUN->IDLE. DRAIN->IDLE when busy is 0. DRAIN->RUN on enable=1.
  - Draining continues regardless of enable.
- ovf: clr_ovf clears all bits; a drop in the same cycle as clr_ovf leaves that bit set (set wins).
- Simultaneous strobes on all channels in one cycle:
  - All are accepted if their FIFOs have space.
  - They are emitted in RR order from the current pointer, one per accepted transfer.

Test Plan:
- Reset, enable=1, ch_str[2]=1 with ptime=5 at coarse=10 -> after the next edge: out_valid=1, out_ch=2, out_coarse=10, out_fine=5; busy=1 until accepted.
- Strobe on all 4 channels in one cycle, pointer=0, out_ready=1 -> events emitted on 4 consecutive cycles as ch 0,1,2,3 with identical out_coarse; pointer ends at 0.
- out_ready=0, three strobes on ch1 (DEPTH=2) -> out_* hold the first event; FIFO holds the 2nd and 3rd; a 4th strobe sets ovf[1]=1 and is lost. Then out_ready=1 -> events 1, 2, 3 emitted in order.
- FIFO full with pop and push at the same edge -> no drop, ovf stays 0; clr_ovf=1 coinciding with a drop -> ovf bit remains 1.
- Coarse counter at 16'hFFFF with a strobe -> event has coarse=0xFFFF; the next cycle's strobe has coarse=0x0000.
- enable falls with 3 events buffered -> FSM DRAIN, all 3 emitted, then busy=0 and IDLE. Strobes during DRAIN are ignored. Re-enable -> counter restarts at 0. Async rst asserted mid-drain -> all outputs 0 immediately.
